mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one datapath mux primitive between 2**SELECT_LINES requesters and drives the mux select lines.
- Each requester offers a packet as valid/ready beats, with a last flag on the final beat.
- The grant is locked for a whole packet, then released and re-arbitrated.
- Sits in front of shared output resources: a single DMA port, a shared FIFO write side, and similar.

---
 rtl/mux_arb_pkg.sv | 34 +++
 rtl/mux_rr_arbiter_if.sv | 37 +++
 rtl/mux_bus.sv | 32 +++
 rtl/mux_prim.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and
// the wrap-around priority pick used during arbitration.
package mux_arb_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Upper bound on select width supported by rr_pick; vectors are
  // zero-extended to MAX_N bits before the call.
  localparam int MAX_SEL = 8;
  localparam int MAX_N   = 1 << MAX_SEL;

  // Index of the first set bit of valid at or after ptr, wrapping at n.
  // n must be a power of two. When no bit is set the result is ptr, which
  // callers never consume because they only use it when a request exists.
  function automatic logic [MAX_SEL-1:0] rr_pick(input logic [MAX_N-1:0] valid,
                                                 input int               ptr,
                                                 input int               n);
    logic [MAX_SEL-1:0] pick;
    int                 idx;
    pick = MAX_SEL'(ptr);
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) & (n - 1);
        if (valid[idx[MAX_SEL-1:0]]) begin
          pick = idx[MAX_SEL-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bundle of the requester-side and downstream-side beat signals.
//
// Handshake: a beat moves on a rising clk edge where valid and ready are
// both high. valid never depends combinationally on ready; ready may depend
// on the downstream ready. last is only meaningful while valid is high and
// marks the final beat of a packet.
interface mux_rr_arbiter_if #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8
);
  localparam int N = 1 << SELECT_LINES;

  // Requester side
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic [N-1:0]            in_ready;

  // Downstream side
  logic                    out_valid;
  logic                    out_last;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_ready;

  // Environment: drives requests and downstream ready.
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );

  // Arbiter: consumes requests, drives the muxed beat and per-requester ready.
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );

endinterface

// File: rtl/mux_bus.sv
// DATA_WIDTH-wide mux built from one mux_prim per bit. Bit b of every
// requester is gathered into a column vector feeding that bit's primitive.
module mux_bus #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8,
  parameter     ARCHITECTURE = "BEHAVIORAL"
) (
  input  logic [(1 << SELECT_LINES)*DATA_WIDTH-1:0] data_i,
  input  logic [SELECT_LINES-1:0]                   sel_i,
  output logic [DATA_WIDTH-1:0]                     data_o
);

  localparam int N = 1 << SELECT_LINES;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    logic [N-1:0] col;

    for (genvar k = 0; k < N; k++) begin : g_req
      assign col[k] = data_i[k*DATA_WIDTH + b];
    end

    mux_prim #(
      .SELECT_LINES (SELECT_LINES),
      .ARCHITECTURE (ARCHITECTURE)
    ) u_mux (
      .data_i (col),
      .sel_i  (sel_i),
      .y_o    (data_o[b])
    );
  end

endmodule

// File: rtl/mux_prim.sv
// One-bit 2**SELECT_LINES:1 mux primitive. ARCHITECTURE picks between an
// indexed behavioural description and a decode-and-OR form.
module mux_prim #(
  parameter int SELECT_LINES = 2,
  parameter     ARCHITECTURE = "BEHAVIORAL"
) (
  input  logic [(1 << SELECT_LINES)-1:0] data_i,
  input  logic [SELECT_LINES-1:0]        sel_i,
  output logic                           y_o
);

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
    assign y_o = data_i[sel_i];
  end else begin : g_andor
    logic [(1 << SELECT_LINES)-1:0] dec;

    // One-hot decode of the select lines.
    always_comb begin
      dec        = '0;
      dec[sel_i] = 1'b1;
    end

    assign y_o = |(dec & data_i);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter in front of a shared mux. A grant is taken in
// IDLE, held in LOCKED for a whole packet (bubbles included), and released
// after the last beat transfers. There is always one IDLE cycle between
// packets, and the round-robin pointer moves to the requester after the
// one just served.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 8,
  parameter     ARCHITECTURE = "BEHAVIORAL"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux_rr_arbiter_if.slave         bus,
  output logic [SELECT_LINES-1:0] select,
  output logic                    busy,
  output logic                    state_o,
  output logic [SELECT_LINES-1:0] rr_ptr_o
);

  localparam int N = 1 << SELECT_LINES;

  logic                    state_q, state_d;
  logic [SELECT_LINES-1:0] select_q, select_d;
  logic [SELECT_LINES-1:0] ptr_q, ptr_d;
  logic                    busy_q, busy_d;

  logic [MAX_N-1:0]        valid_ext;
  logic [SELECT_LINES-1:0] pick;
  logic [N-1:0]            grant_onehot;

  logic                    out_valid_w;
  logic                    out_last_w;
  logic [N-1:0]            in_ready_w;
  logic                    xfer_last;

  // Widen the request vector to the pick function's fixed width.
  always_comb begin
    valid_ext         = '0;
    valid_ext[N-1:0]  = bus.in_valid;
  end

  assign pick         = SELECT_LINES'(rr_pick(valid_ext, int'(ptr_q), N));
  assign grant_onehot = N'(1) << select_q;
  assign xfer_last    = out_valid_w & bus.out_ready & out_last_w;

  // State register: FSM state, grant index, round-robin pointer, busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      select_q <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  // Next state: grant in IDLE, release after the last beat of the packet.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.in_valid) begin
          state_d  = ST_LOCKED;
          select_d = pick;
          busy_d   = 1'b1;
        end
      end
      default: begin
        if (xfer_last) begin
          state_d = ST_IDLE;
          ptr_d   = select_q + SELECT_LINES'(1);
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // Outputs: forward the granted requester's handshake only while LOCKED.
  always_comb begin
    out_valid_w = 1'b0;
    out_last_w  = 1'b0;
    in_ready_w  = '0;
    if (state_q == ST_LOCKED) begin
      out_valid_w = bus.in_valid[select_q];
      out_last_w  = bus.in_last[select_q] & bus.in_valid[select_q];
      in_ready_w  = grant_onehot & {N{bus.out_ready}};
    end
  end

  mux_bus #(
    .SELECT_LINES (SELECT_LINES),
    .DATA_WIDTH   (DATA_WIDTH),
    .ARCHITECTURE (ARCHITECTURE)
  ) u_mux_bus (
    .data_i (bus.in_data),
    .sel_i  (select_q),
    .data_o (bus.out_data)
  );

  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_last_w;
  assign bus.in_ready  = in_ready_w;

  assign select   = select_q;
  assign busy     = busy_q;
  assign state_o  = state_q;
  assign rr_ptr_o = ptr_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (SELECT_LINES=2, DATA_WIDTH=8).
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int SL = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SL-1:0] select;
  logic          busy;
  logic          dbg_state;
  logic [SL-1:0] rr_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SL-1:0] exp_q[$];

  mux_rr_arbiter_if #(.SELECT_LINES(SL), .DATA_WIDTH(DW)) bus ();

  mux_rr_arbiter #(
    .SELECT_LINES (SL),
    .DATA_WIDTH   (DW),
    .ARCHITECTURE ("BEHAVIORAL")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .select   (select),
    .busy     (busy),
    .state_o  (dbg_state),
    .rr_ptr_o (rr_ptr)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic l, input logic [DW-1:0] d);
    bus.in_valid[k]          = v;
    bus.in_last[k]           = l;
    bus.in_data[k*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
  endtask

  // Assert reset between edges, check it took effect without a clock, release.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_select"},    32'(select),       32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    check({tag, "_state"},     32'(dbg_state),    32'(ST_IDLE));
    check({tag, "_ptr"},       32'(rr_ptr),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_reqs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SL-1:0] g;

    // ---------------- Reset values ----------------
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    clear_reqs();
    #2;
    check("rst_select",    32'(select),        32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_ptr",       32'(rr_ptr),        32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---------------- T1: single-beat packet on requester 2 ----------------
    tick();
    check("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
    set_req(2, 1'b1, 1'b1, 8'hA5);
    bus.out_ready = 1'b1;
    settle();
    check("t1_pre_out_valid", 32'(bus.out_valid), 32'd0);
    check("t1_pre_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    check("t1_select",    32'(select),        32'd2);
    check("t1_busy",      32'(busy),          32'd1);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_data",  32'(bus.out_data),  32'hA5);
    check("t1_out_last",  32'(bus.out_last),  32'd1);
    check("t1_in_ready",  32'(bus.in_ready),  32'b0100);
    tick();
    check("t1_done_busy",  32'(busy),          32'd0);
    check("t1_done_ptr",   32'(rr_ptr),        32'd3);
    check("t1_done_state", 32'(dbg_state),     32'(ST_IDLE));
    check("t1_done_sel",   32'(select),        32'd2);
    check("t1_done_ov",    32'(bus.out_valid), 32'd0);
    clear_reqs();

    // ---------------- T5: pointer wrap 3 -> 0 ----------------
    set_req(3, 1'b1, 1'b1, 8'h3C);
    tick();
    check("t5_sel3",  32'(select),       32'd3);
    check("t5_data3", 32'(bus.out_data), 32'h3C);
    tick();
    check("t5_ptr0",  32'(rr_ptr),       32'd0);
    check("t5_idle",  32'(dbg_state),    32'(ST_IDLE));
    set_req(0, 1'b1, 1'b1, 8'h0F);
    tick();
    check("t5_sel0",      32'(select),       32'd0);
    check("t5_in_ready0", 32'(bus.in_ready), 32'b0001);
    check("t5_data0",     32'(bus.out_data), 32'h0F);

    // ---------------- T4: downstream stall while LOCKED ----------------
    bus.out_ready = 1'b0;
    settle();
    check("t4_in_ready",  32'(bus.in_ready),  32'd0);
    check("t4_out_valid", 32'(bus.out_valid), 32'd1);
    check("t4_out_last",  32'(bus.out_last),  32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_hold_state", 32'(dbg_state),    32'(ST_LOCKED));
      check("t4_hold_sel",   32'(select),       32'd0);
      check("t4_hold_data",  32'(bus.out_data), 32'h0F);
      check("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    settle();
    check("t4_release_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    check("t4_done_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_done_ptr",   32'(rr_ptr),    32'd1);
    check("t4_done_busy",  32'(busy),      32'd0);
    set_req(0, 1'b0, 1'b0, 8'h00);
    tick();
    check("t4_next_sel3", 32'(select), 32'd3);
    tick();
    check("t4_next_ptr", 32'(rr_ptr), 32'd0);
    clear_reqs();

    // ---------------- T3: bubble mid-packet, no stealing ----------------
    set_req(1, 1'b1, 1'b0, 8'h10);
    tick();
    check("t3_sel1",  32'(select),        32'd1);
    check("t3_ov",    32'(bus.out_valid), 32'd1);
    check("t3_data",  32'(bus.out_data),  32'h10);
    check("t3_last0", 32'(bus.out_last),  32'd0);
    set_req(3, 1'b1, 1'b1, 8'h30);
    tick();
    set_req(1, 1'b0, 1'b0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_bubble_ov",    32'(bus.out_valid), 32'd0);
      check("t3_bubble_sel",   32'(select),        32'd1);
      check("t3_bubble_state", 32'(dbg_state),     32'(ST_LOCKED));
      if (i < 2) tick();
    end
    set_req(1, 1'b1, 1'b1, 8'h11);
    settle();
    check("t3_last_ov",   32'(bus.out_valid), 32'd1);
    check("t3_last_flag", 32'(bus.out_last),  32'd1);
    check("t3_last_data", 32'(bus.out_data),  32'h11);
    tick();
    check("t3_rel_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t3_rel_sel",   32'(select),    32'd1);
    check("t3_rel_ptr",   32'(rr_ptr),    32'd2);
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    check("t3_sel3",  32'(select),       32'd3);
    check("t3_data3", 32'(bus.out_data), 32'h30);
    tick();
    check("t3_ptr0", 32'(rr_ptr), 32'd0);
    clear_reqs();

    // ---------------- T2: four requesters, 2-beat packets ----------------
    do_reset("t2_rst");
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, {4'(k), 4'h0});
    settle();
    check("t2_start_idle", 32'(dbg_state), 32'(ST_IDLE));
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      tick();
      check("t2_grant",     32'(select),        32'(g));
      check("t2_b0_data",   32'(bus.out_data),  32'({4'(g), 4'h0}));
      check("t2_b0_last",   32'(bus.out_last),  32'd0);
      check("t2_b0_ready",  32'(bus.in_ready),  32'(4'b0001 << g));
      tick();
      set_req(int'(g), 1'b1, 1'b1, {4'(g), 4'h1});
      settle();
      check("t2_b1_data",   32'(bus.out_data),  32'({4'(g), 4'h1}));
      check("t2_b1_last",   32'(bus.out_last),  32'd1);
      check("t2_b1_sel",    32'(select),        32'(g));
      tick();
      set_req(int'(g), 1'b1, 1'b0, {4'(g), 4'h0});
      settle();
      check("t2_gap_state", 32'(dbg_state),     32'(ST_IDLE));
      check("t2_gap_ov",    32'(bus.out_valid), 32'd0);
    end
    clear_reqs();

    // ---------------- T6: reset mid-packet on requester 2 ----------------
    set_req(2, 1'b1, 1'b0, 8'h20);
    tick();
    check("t6_sel2", 32'(select), 32'd2);
    tick();
    check("t6_busy", 32'(busy), 32'd1);
    do_reset("t6_rst");
    set_req(0, 1'b1, 1'b1, 8'h01);
    set_req(2, 1'b1, 1'b1, 8'h21);
    set_req(3, 1'b1, 1'b1, 8'h31);
    tick();
    check("t6_after_sel",  32'(select),       32'd0);
    check("t6_after_data", 32'(bus.out_data), 32'h01);
    clear_reqs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
